// File: rtl/max6951_link_arbiter_if.sv
// Handshake bundle between display requesters, the link arbiter and the MAX6951 bit serializer.
// The arbiter takes the master view; the environment (requesters + serializer) takes the slave view.
interface max6951_link_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  ser_valid;
    logic [15:0]           ser_data;
    logic                  ser_ready;
    logic                  ser_done;

    modport master (
        input  req_valid,
        input  req_data,
        output req_ready,
        output ser_valid,
        output ser_data,
        input  ser_ready,
        input  ser_done
    );

    modport slave (
        output req_valid,
        output req_data,
        input  req_ready,
        input  ser_valid,
        input  ser_data,
        output ser_ready,
        output ser_done
    );
endinterface

// File: rtl/max6951_link_arbiter.sv
// Shares the single MAX6951 serial write link: plays the init ROM after reset/reinit,
// then round-robins 16-bit register-write words from NUM_REQ clients into the serializer.
module max6951_link_arbiter #(
    parameter int          NUM_REQ    = 4,
    parameter logic [3:0]  INTENSITY  = 4'hF,
    parameter logic [2:0]  SCAN_LIMIT = 3'd7,
    parameter logic [7:0]  DECODE     = 8'hFF,
    localparam int         IDW        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   resetn,
    max6951_link_arbiter_if.master bus,
    input  logic                   reinit,
    output logic [IDW-1:0]         grant_id,
    output logic                   init_done,
    output logic                   busy
);

    typedef enum logic [2:0] {
        ST_INIT_ISSUE = 3'd0,
        ST_INIT_WAIT  = 3'd1,
        ST_ARB        = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_WAIT       = 3'd4
    } state_t;

    function automatic logic [15:0] rom_word(input logic [1:0] idx);
        case (idx)
            2'd0:    return 16'h0401;
            2'd1:    return {8'h02, 4'h0, INTENSITY};
            2'd2:    return {8'h03, 5'h00, SCAN_LIMIT};
            2'd3:    return {8'h01, DECODE};
            default: return 16'h0401;
        endcase
    endfunction

    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] sel);
        if (sel == IDW'(NUM_REQ - 1)) begin
            return '0;
        end else begin
            return sel + IDW'(1);
        end
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [1:0]       r_init_idx;
    logic [1:0]       w_next_idx;
    logic [IDW-1:0]   r_rr_ptr;
    logic             r_reinit_pend;
    logic             r_ser_valid;
    logic [15:0]      r_ser_data;
    logic [IDW-1:0]   r_grant_id;
    logic             r_init_done;
    logic             r_busy;

    logic             w_hs;
    logic             w_take_reinit;
    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic [15:0]      w_sel_word;
    logic             w_grant;
    logic             w_init_last;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [15:0]      w_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign w_words[g] = bus.req_data[16*g +: 16];
    end

    // The handshake is judged on the registered ser_valid the serializer actually sees.
    assign w_hs          = r_ser_valid & bus.ser_ready;
    assign w_take_reinit = (r_state == ST_ARB) & (reinit | r_reinit_pend);
    assign w_grant       = (r_state == ST_ARB) & ~w_take_reinit & w_found;
    assign w_init_last   = (r_state == ST_INIT_WAIT) & bus.ser_done & (r_init_idx == 2'd3);

    // Round-robin search: first valid requester at or after rr_ptr, wrapping at NUM_REQ-1.
    always_comb begin
        logic [IDW:0]   w_sum;
        logic [IDW-1:0] w_idx;
        w_found    = 1'b0;
        w_sel      = '0;
        w_sel_word = 16'h0000;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_sel      = w_idx;
                w_sel_word = w_words[w_idx];
            end else begin
                w_found    = w_found;
            end
        end
    end

    // State register and init ROM index.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_INIT_ISSUE;
            r_init_idx <= 2'd0;
        end else begin
            r_state    <= w_next_state;
            r_init_idx <= w_next_idx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_init_idx;
        case (r_state)
            ST_INIT_ISSUE: begin
                if (w_hs) begin
                    w_next_state = ST_INIT_WAIT;
                end else begin
                    w_next_state = ST_INIT_ISSUE;
                end
            end
            ST_INIT_WAIT: begin
                if (bus.ser_done) begin
                    if (r_init_idx == 2'd3) begin
                        w_next_idx   = 2'd0;
                        w_next_state = ST_ARB;
                    end else begin
                        w_next_idx   = r_init_idx + 2'd1;
                        w_next_state = ST_INIT_ISSUE;
                    end
                end else begin
                    w_next_state = ST_INIT_WAIT;
                end
            end
            ST_ARB: begin
                if (w_take_reinit) begin
                    w_next_idx   = 2'd0;
                    w_next_state = ST_INIT_ISSUE;
                end else if (w_found) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_ARB;
                end
            end
            ST_ISSUE: begin
                if (w_hs) begin
                    w_next_state = ST_WAIT;
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.ser_done) begin
                    w_next_state = ST_ARB;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            default: begin
                w_next_idx   = 2'd0;
                w_next_state = ST_INIT_ISSUE;
            end
        endcase
    end

    // Output logic: req_ready must be combinational so the grant lands in the search cycle.
    always_comb begin
        w_req_ready = '0;
        if (w_grant) begin
            w_req_ready[w_sel] = 1'b1;
        end else begin
            w_req_ready = '0;
        end
    end

    // Registered link outputs, grant bookkeeping and deferred reinit request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ser_valid   <= 1'b0;
            r_ser_data    <= 16'h0000;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_init_done   <= 1'b0;
            r_busy        <= 1'b1;
            r_reinit_pend <= 1'b0;
        end else begin
            r_ser_valid <= (w_next_state == ST_INIT_ISSUE) || (w_next_state == ST_ISSUE);
            r_busy      <= (w_next_state != ST_ARB);
            if (w_next_state == ST_INIT_ISSUE) begin
                r_ser_data <= rom_word(w_next_idx);
            end else if (w_grant) begin
                r_ser_data <= w_sel_word;
            end else begin
                r_ser_data <= r_ser_data;
            end
            if (w_grant) begin
                r_grant_id <= w_sel;
                r_rr_ptr   <= ptr_after(w_sel);
            end else begin
                r_grant_id <= r_grant_id;
                r_rr_ptr   <= r_rr_ptr;
            end
            if (w_init_last) begin
                r_init_done <= 1'b1;
            end else if (w_take_reinit) begin
                r_init_done <= 1'b0;
            end else begin
                r_init_done <= r_init_done;
            end
            // A reinit outside ARB waits until the in-flight word has fully left the link.
            if (w_take_reinit) begin
                r_reinit_pend <= 1'b0;
            end else if (reinit && (r_state != ST_ARB)) begin
                r_reinit_pend <= 1'b1;
            end else begin
                r_reinit_pend <= r_reinit_pend;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.ser_valid = r_ser_valid;
    assign bus.ser_data  = r_ser_data;
    assign grant_id      = r_grant_id;
    assign init_done     = r_init_done;
    assign busy          = r_busy;

endmodule

// File: tb/tb_max6951_link_arbiter.sv
// Bench for max6951_link_arbiter: transaction-level link model checked every cycle,
// directed scenarios pinned with literal expectations, then a randomized soak.
module tb_max6951_link_arbiter;
    localparam int N = 4;

    logic       clk;
    logic       resetn;
    logic       reinit;
    logic [1:0] grant_id;
    logic       init_done;
    logic       busy;

    max6951_link_arbiter_if #(.NUM_REQ(N)) bus ();

    max6951_link_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .reinit    (reinit),
        .grant_id  (grant_id),
        .init_done (init_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] ROM_W [4] = '{16'h0401, 16'h020F, 16'h0307, 16'h01FF};

    // Link model: the link is free, has a word on offer, or has a word being shifted out.
    localparam int PH_FREE = 0, PH_OFFER = 1, PH_SHIFT = 2;
    int          m_ph;
    bit          m_show;
    logic [15:0] m_word;
    int          m_ptr;
    int          m_gid;
    bit          m_idone;
    bit          m_in_init;
    int          m_ipos;
    bit          m_pend;
    int          m_sel;
    logic [3:0]  m_erdy;

    // Observations handed to the serializer model and directed checks.
    bit          acc_ev = 1'b0;
    bit          rst_seen = 1'b1;
    logic [15:0] hs_log [$];
    int          grant_log [$];

    // Serializer model knobs.
    bit hold = 1'b0;
    bit rand_ready = 1'b0;
    bit spur_en = 1'b0;
    bit inj_done = 1'b0;
    int ser_len = 16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = PH_OFFER; m_show = 1'b0; m_word = 16'h0000; m_ptr = 0; m_gid = 0;
        m_idone = 1'b0; m_in_init = 1'b1; m_ipos = 0; m_pend = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] s2;
        case (m_ph)
            PH_OFFER: begin
                if (!m_show) begin
                    m_show = 1'b1;
                    m_word = ROM_W[m_ipos];
                end else if (bus.ser_ready) begin
                    m_ph = PH_SHIFT;
                    m_show = 1'b0;
                end
                if (reinit) m_pend = 1'b1;
            end
            PH_SHIFT: begin
                if (reinit) m_pend = 1'b1;
                if (bus.ser_done) begin
                    if (m_in_init && m_ipos == 3) begin
                        m_in_init = 1'b0; m_ipos = 0; m_idone = 1'b1; m_ph = PH_FREE;
                    end else if (m_in_init) begin
                        m_ipos++; m_ph = PH_OFFER; m_show = 1'b1; m_word = ROM_W[m_ipos];
                    end else begin
                        m_ph = PH_FREE;
                    end
                end
            end
            default: begin
                if (reinit || m_pend) begin
                    m_pend = 1'b0; m_idone = 1'b0; m_in_init = 1'b1; m_ipos = 0;
                    m_ph = PH_OFFER; m_show = 1'b1; m_word = ROM_W[0];
                end else if (m_sel >= 0) begin
                    s2 = 2'(m_sel);
                    m_word = bus.req_data[16*s2 +: 16];
                    m_gid = m_sel; m_ptr = (m_sel + 1) % N;
                    m_ph = PH_OFFER; m_show = 1'b1;
                end
            end
        endcase
    endtask

    // Compare process: check DUT against the model mid-cycle, log handshakes, then advance the model.
    always @(negedge clk) begin
        logic [1:0] jj;
        if (!resetn) begin
            model_reset();
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
        end
        m_sel = -1;
        m_erdy = 4'b0000;
        if (resetn && m_ph == PH_FREE && !(reinit || m_pend)) begin
            for (int k = 0; k < N; k++) begin
                jj = 2'((m_ptr + k) % N);
                if (m_sel < 0 && bus.req_valid[jj]) m_sel = int'(jj);
            end
        end
        if (m_sel >= 0) m_erdy[2'(m_sel)] = 1'b1;
        chk("ser_valid", 32'(bus.ser_valid), 32'(m_show));
        chk("ser_data", 32'(bus.ser_data), 32'(m_word));
        chk("req_ready", 32'(bus.req_ready), 32'(m_erdy));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("init_done", 32'(init_done), 32'(m_idone));
        chk("busy", 32'(busy), 32'(m_ph != PH_FREE));
        acc_ev = 1'b0;
        if (resetn) begin
            if (bus.ser_valid && bus.ser_ready) begin
                hs_log.push_back(bus.ser_data);
                acc_ev = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                jj = 2'(k);
                if (bus.req_valid[jj] && bus.req_ready[jj]) grant_log.push_back(k);
            end
            model_step();
        end
    end

    // Serializer model: accepts words, pulses ser_done ser_len cycles later, may emit stray pulses when idle.
    initial begin
        int cnt;
        cnt = 0;
        bus.ser_ready = 1'b0;
        bus.ser_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.ser_done = 1'b0;
            if (rst_seen) begin
                cnt = 0;
            end else if (acc_ev) begin
                cnt = ser_len;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.ser_done = 1'b1;
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                bus.ser_done = 1'b1;
            end
            if (inj_done) bus.ser_done = 1'b1;
            bus.ser_ready = hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gr(input int n);
        int t = 0;
        while (grant_log.size() < n && t < 2000) begin tick(); t++; end
        chk("wait_grant", 32'(grant_log.size() >= n), 32'd1);
    endtask

    task automatic wait_hs(input int n);
        int t = 0;
        while (hs_log.size() < n && t < 2000) begin tick(); t++; end
        chk("wait_handshake", 32'(hs_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idone(input logic v);
        int t = 0;
        while (init_done !== v && t < 2000) begin tick(); t++; end
        chk("wait_init_done", 32'(init_done), 32'(v));
    endtask

    initial begin
        int n;
        int g0;
        resetn = 1'b0;
        reinit = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data = {16'h6003, 16'h6002, 16'h6001, 16'h6000};
        repeat (3) tick();
        resetn = 1'b1;

        // Init sequence with all requesters already asking; nobody may be granted yet.
        wait_idone(1'b1);
        chk("init_word_count", 32'(hs_log.size()), 32'd4);
        chk("init_grants", 32'(grant_log.size()), 32'd0);
        for (int i = 0; i < 4; i++) chk("init_word", 32'(hs_log[i]), 32'(ROM_W[i]));

        // All requesters valid: strict rotation.
        wait_gr(7);
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 7; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % 4));
        wait_hs(8);
        chk("rr_word0", 32'(hs_log[4]), 32'h6000);
        chk("rr_word3", 32'(hs_log[7]), 32'h6003);

        // rr_ptr=3, only requester 2: search wraps to 2, then requester 3 is next in line.
        bus.req_valid = 4'b0100;
        wait_gr(8);
        bus.req_valid = 4'b0000;
        chk("wrap_grant", 32'(grant_log[7]), 32'd2);
        tick();
        chk("wrap_grant_id", 32'(grant_id), 32'd2);
        bus.req_valid = 4'b1111;
        wait_gr(9);
        bus.req_valid = 4'b0000;
        chk("ptr_after_wrap", 32'(grant_log[8]), 32'd3);

        // reinit during a client word: word finishes, init replays, client served afterwards.
        bus.req_valid = 4'b0010;
        wait_gr(10);
        n = hs_log.size();
        wait_hs(n + 1);
        reinit = 1'b1;
        tick();
        reinit = 1'b0;
        wait_idone(1'b0);
        wait_idone(1'b1);
        wait_gr(11);
        bus.req_valid = 4'b0000;
        wait_hs(n + 6);
        chk("reinit_client_word", 32'(hs_log[n]), 32'h6001);
        for (int i = 0; i < 4; i++) chk("reinit_rom", 32'(hs_log[n + 1 + i]), 32'(ROM_W[i]));
        chk("reinit_then_grant", 32'(grant_log[10]), 32'd1);
        chk("reinit_then_word", 32'(hs_log[n + 5]), 32'h6001);

        // Serializer stalls in ISSUE with a stray ser_done: word held, state unchanged.
        hold = 1'b1;
        bus.req_valid = 4'b0001;
        wait_gr(12);
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.ser_valid), 32'd1);
            chk("stall_data", 32'(bus.ser_data), 32'h6000);
            inj_done = (i == 4);
            tick();
        end
        inj_done = 1'b0;
        chk("stall_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        n = hs_log.size();
        wait_hs(n + 1);

        // Reset while a word is shifting.
        bus.req_valid = 4'b0001;
        wait_gr(13);
        bus.req_valid = 4'b0000;
        n = hs_log.size();
        wait_hs(n + 1);
        repeat (3) tick();
        resetn = 1'b0;
        #2;
        chk("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        repeat (2) tick();
        resetn = 1'b1;
        n = hs_log.size();
        wait_hs(n + 1);
        chk("rst_restart_word", 32'(hs_log[n]), 32'h0401);
        wait_idone(1'b1);

        // Randomized soak against the model.
        rand_ready = 1'b1;
        spur_en = 1'b1;
        g0 = grant_log.size();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req_valid = 4'($urandom);
            if ($urandom_range(0, 7) == 0) bus.req_data = {$urandom, $urandom};
            ser_len = $urandom_range(1, 20);
            reinit = !reinit && ($urandom_range(0, 149) == 0);
            if (c == 2000) resetn = 1'b0;
            if (c == 2003) resetn = 1'b1;
            tick();
        end
        reinit = 1'b0;
        bus.req_valid = 4'b0000;
        chk("random_progress", 32'(grant_log.size() > g0 + 20), 32'd1);
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
